// File: rtl/instr_fetch_decode_pkg.sv
// Shared types for the Tomasulo front end: decoded control word, op class,
// fetch FSM states and RV32I opcode constants.
package tomasula_types;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h4000_0060;
  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;

  typedef enum logic [2:0] {
    ALU   = 3'd0,
    LD    = 3'd1,
    ST    = 3'd2,
    BR    = 3'd3,
    JAL   = 3'd4,
    JALR  = 3'd5,
    LUI   = 3'd6,
    AUIPC = 3'd7
  } op_t;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2
  } fetch_state_t;

  typedef struct packed {
    op_t         op;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [4:0]  rd;
    logic [4:0]  src1_reg;
    logic [4:0]  src2_reg;
    logic [31:0] imm;
    logic [31:0] pc;
  } ctl_word;

endpackage

// File: rtl/iq_2_ir.sv
// Handshake between the fetch/decode stage (IR side) and the instruction queue.
interface IQ_2_IR;
  import tomasula_types::*;

  logic    ld_iq;
  ctl_word control_word;
  logic    ack_o;
  logic    issue_q_full_n;

  modport IR_SIG (output ld_iq, control_word, input ack_o, issue_q_full_n);
  modport IQ_SIG (input ld_iq, control_word, output ack_o, issue_q_full_n);
endinterface

// File: rtl/instr_fetch_decode_rv32i_decoder.sv
// Purely combinational RV32I decoder: instruction word plus its PC to ctl_word.
module rv32i_decoder
  import tomasula_types::*;
(
  input  logic [31:0] instr,
  input  logic [31:0] pc,
  output ctl_word     ctl
);

  logic [6:0]  opcode_s;
  logic [31:0] imm_i_s;
  logic [31:0] imm_s_s;
  logic [31:0] imm_b_s;
  logic [31:0] imm_u_s;
  logic [31:0] imm_j_s;

  assign opcode_s = instr[6:0];
  assign imm_i_s  = {{20{instr[31]}}, instr[31:20]};
  assign imm_s_s  = {{20{instr[31]}}, instr[31:25], instr[11:7]};
  assign imm_b_s  = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
  assign imm_u_s  = {instr[31:12], 12'h000};
  assign imm_j_s  = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

  // Field extraction with per-format zeroing of unused register fields.
  always_comb begin
    ctl.op       = ALU;
    ctl.funct3   = instr[14:12];
    ctl.funct7   = instr[31:25];
    ctl.rd       = instr[11:7];
    ctl.src1_reg = instr[19:15];
    ctl.src2_reg = instr[24:20];
    ctl.imm      = 32'h0000_0000;
    ctl.pc       = pc;
    case (opcode_s)
      OPC_OP: begin
        ctl.op = ALU;
      end
      OPC_OP_IMM: begin
        ctl.op       = ALU;
        ctl.src2_reg = 5'd0;
        ctl.imm      = imm_i_s;
      end
      OPC_LOAD: begin
        ctl.op       = LD;
        ctl.src2_reg = 5'd0;
        ctl.imm      = imm_i_s;
      end
      OPC_STORE: begin
        ctl.op  = ST;
        ctl.rd  = 5'd0;
        ctl.imm = imm_s_s;
      end
      OPC_BRANCH: begin
        ctl.op  = BR;
        ctl.rd  = 5'd0;
        ctl.imm = imm_b_s;
      end
      OPC_JAL: begin
        ctl.op       = JAL;
        ctl.src1_reg = 5'd0;
        ctl.src2_reg = 5'd0;
        ctl.imm      = imm_j_s;
      end
      OPC_JALR: begin
        ctl.op       = JALR;
        ctl.src2_reg = 5'd0;
        ctl.imm      = imm_i_s;
      end
      OPC_LUI: begin
        ctl.op       = LUI;
        ctl.src1_reg = 5'd0;
        ctl.src2_reg = 5'd0;
        ctl.imm      = imm_u_s;
      end
      OPC_AUIPC: begin
        ctl.op       = AUIPC;
        ctl.src1_reg = 5'd0;
        ctl.src2_reg = 5'd0;
        ctl.imm      = imm_u_s;
      end
      default: begin
        // Unknown opcodes become a harmless ALU op writing x0.
        ctl.op = ALU;
        ctl.rd = 5'd0;
      end
    endcase
  end

endmodule

// File: rtl/instr_fetch_decode.sv
// Fetch/decode front end: owns the fetch PC, fetches one instruction at a
// time and offers its decode to the instruction queue.
module instr_fetch_decode
  import tomasula_types::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_address,
  output logic        imem_read,
  input  logic        imem_resp,
  input  logic [31:0] imem_rdata,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  IQ_2_IR.IR_SIG      iq_ir_itf
);

  fetch_state_t state_r, state_next_s;
  logic [31:0]  pc_r, pc_next_s;
  logic [31:0]  pend_pc_r, pend_pc_next_s;
  logic [31:0]  ir_r, ir_next_s;
  ctl_word      decoded_s;

  // State, PC, pending redirect target and instruction register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= FETCH;
      pc_r      <= RESET_PC;
      pend_pc_r <= 32'h0000_0000;
      ir_r      <= NOP_INSTR;
    end else begin
      state_r   <= state_next_s;
      pc_r      <= pc_next_s;
      pend_pc_r <= pend_pc_next_s;
      ir_r      <= ir_next_s;
    end
  end

  // Next-state logic; redirect always beats a same-cycle fetch or enqueue.
  always_comb begin
    state_next_s   = state_r;
    pc_next_s      = pc_r;
    pend_pc_next_s = pend_pc_r;
    ir_next_s      = ir_r;
    case (state_r)
      FETCH: begin
        if (imem_resp && redirect) begin
          pc_next_s = redirect_pc;
        end else if (imem_resp) begin
          ir_next_s    = imem_rdata;
          state_next_s = ISSUE;
        end else if (redirect) begin
          pend_pc_next_s = redirect_pc;
          state_next_s   = DRAIN;
        end else begin
          state_next_s = FETCH;
        end
      end
      DRAIN: begin
        // The outstanding read must complete on the old address before refetching.
        if (imem_resp) begin
          pc_next_s    = redirect ? redirect_pc : pend_pc_r;
          state_next_s = FETCH;
        end else if (redirect) begin
          pend_pc_next_s = redirect_pc;
        end else begin
          state_next_s = DRAIN;
        end
      end
      ISSUE: begin
        if (redirect) begin
          pc_next_s    = redirect_pc;
          state_next_s = FETCH;
        end else if (iq_ir_itf.ack_o) begin
          pc_next_s    = pc_r + 32'd4;
          state_next_s = FETCH;
        end else begin
          state_next_s = ISSUE;
        end
      end
      default: begin
        state_next_s = FETCH;
      end
    endcase
  end

  rv32i_decoder u_decoder (
    .instr (ir_r),
    .pc    (pc_r),
    .ctl   (decoded_s)
  );

  assign imem_address           = pc_r;
  assign imem_read              = (state_r == FETCH) || (state_r == DRAIN);
  assign iq_ir_itf.ld_iq        = (state_r == ISSUE);
  assign iq_ir_itf.control_word = decoded_s;

endmodule

// File: tb/tb_instr_fetch_decode.sv
// Directed-vector bench with a scoreboard for fetch addresses and enqueued control words.
module tb_instr_fetch_decode;
  import tomasula_types::*;

  logic        clk;
  logic        rst;
  logic [31:0] imem_address;
  logic        imem_read;
  logic        imem_resp;
  logic [31:0] imem_rdata;
  logic        redirect;
  logic [31:0] redirect_pc;

  IQ_2_IR iq_if ();

  instr_fetch_decode #(.RESET_PC(32'h4000_0060)) dut (
    .clk          (clk),
    .rst          (rst),
    .imem_address (imem_address),
    .imem_read    (imem_read),
    .imem_resp    (imem_resp),
    .imem_rdata   (imem_rdata),
    .redirect     (redirect),
    .redirect_pc  (redirect_pc),
    .iq_ir_itf    (iq_if)
  );

  int errors = 0;
  int checks = 0;
  ctl_word     exp_q[$];
  logic [31:0] addr_q[$];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  function automatic ctl_word mk(input op_t op, input logic [2:0] f3, input logic [6:0] f7,
                                 input logic [4:0] rd, input logic [4:0] s1, input logic [4:0] s2,
                                 input logic [31:0] imm, input logic [31:0] pc);
    ctl_word c;
    c.op = op; c.funct3 = f3; c.funct7 = f7; c.rd = rd;
    c.src1_reg = s1; c.src2_reg = s2; c.imm = imm; c.pc = pc;
    return c;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits (bounded) for a fetch request, then answers after lat wait cycles.
  task automatic mem_fetch(input logic [31:0] data, input int lat, input logic [31:0] addr);
    int n = 0;
    while (imem_read !== 1'b1 && n < 16) begin
      tick();
      n++;
    end
    check("fetch_req", {31'd0, imem_read}, 32'd1);
    addr_q.push_back(addr);
    repeat (lat) tick();
    imem_resp  = 1'b1;
    imem_rdata = data;
    tick();
    imem_resp  = 1'b0;
    imem_rdata = 32'h0000_0000;
  endtask

  // Monitor: checks fetch address on each response and the control word while ld_iq is high.
  always @(negedge clk) begin
    if (imem_resp === 1'b1) begin
      if (addr_q.size() == 0) begin
        checks++; errors++;
        $display("FAIL fetch_addr: got unexpected response at %h expected none", imem_address);
      end else begin
        check("fetch_addr", imem_address, addr_q.pop_front());
      end
    end
    if (iq_if.ld_iq === 1'b1) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL ctl_word: got unexpected ld_iq with %h expected none", iq_if.control_word);
      end else begin
        if (iq_if.control_word !== exp_q[0]) begin
          errors++;
          $display("FAIL ctl_word: got %h expected %h", iq_if.control_word, exp_q[0]);
        end
        if (iq_if.ack_o === 1'b1 || redirect === 1'b1) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    rst = 1'b1; imem_resp = 1'b0; imem_rdata = 32'h0; redirect = 1'b0; redirect_pc = 32'h0;
    iq_if.ack_o = 1'b0; iq_if.issue_q_full_n = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    check("reset_addr", imem_address, 32'h4000_0060);
    check("reset_read", {31'd0, imem_read}, 32'd1);
    check("reset_ld_iq", {31'd0, iq_if.ld_iq}, 32'd0);

    // addi x1,x2,5 with ack tied high
    iq_if.ack_o = 1'b1;
    exp_q.push_back(mk(ALU, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5, 32'h4000_0060));
    mem_fetch(32'h0051_0093, 1, 32'h4000_0060);
    check("addi_ld_iq", {31'd0, iq_if.ld_iq}, 32'd1);
    tick();
    check("addi_next_addr", imem_address, 32'h4000_0064);

    // sw x3,8(x4) held for 5 cycles without ack
    iq_if.ack_o = 1'b0;
    exp_q.push_back(mk(ST, 3'd2, 7'd0, 5'd0, 5'd4, 5'd3, 32'd8, 32'h4000_0064));
    mem_fetch(32'h0032_2423, 0, 32'h4000_0064);
    repeat (4) tick();
    check("sw_hold_addr", imem_address, 32'h4000_0064);
    check("sw_hold_ld_iq", {31'd0, iq_if.ld_iq}, 32'd1);
    tick();
    iq_if.ack_o = 1'b1;
    tick();
    iq_if.ack_o = 1'b0;
    check("sw_next_addr", imem_address, 32'h4000_0068);

    // latency 4 with redirect on the 2nd wait cycle
    addr_q.push_back(32'h4000_0068);
    tick();
    redirect = 1'b1; redirect_pc = 32'h4000_1000;
    tick();
    redirect = 1'b0;
    check("drain_addr_held", imem_address, 32'h4000_0068);
    check("drain_read", {31'd0, imem_read}, 32'd1);
    tick();
    tick();
    imem_resp = 1'b1; imem_rdata = 32'h0010_0093;
    tick();
    imem_resp = 1'b0;
    check("drain_no_ld_iq", {31'd0, iq_if.ld_iq}, 32'd0);
    check("drain_new_addr", imem_address, 32'h4000_1000);

    // lui x5,0x12345, redirected while waiting for ack
    exp_q.push_back(mk(LUI, 3'd5, 7'd9, 5'd5, 5'd0, 5'd0, 32'h1234_5000, 32'h4000_1000));
    mem_fetch(32'h1234_52B7, 2, 32'h4000_1000);
    redirect = 1'b1; redirect_pc = 32'h4000_2000;
    tick();
    redirect = 1'b0;
    check("issue_redir_ld_iq", {31'd0, iq_if.ld_iq}, 32'd0);
    check("issue_redir_addr", imem_address, 32'h4000_2000);

    // beq x1,x2,-8 with redirect and ack together
    exp_q.push_back(mk(BR, 3'd0, 7'h7F, 5'd0, 5'd1, 5'd2, 32'hFFFF_FFF8, 32'h4000_2000));
    mem_fetch(32'hFE20_8CE3, 0, 32'h4000_2000);
    iq_if.ack_o = 1'b1; redirect = 1'b1; redirect_pc = 32'h4000_2000;
    tick();
    iq_if.ack_o = 1'b0; redirect = 1'b0;
    check("redir_ack_addr", imem_address, 32'h4000_2000);

    // two redirects while draining: the last one wins
    addr_q.push_back(32'h4000_2000);
    redirect = 1'b1; redirect_pc = 32'h1234_0000;
    tick();
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect = 1'b0;
    check("drain2_addr_held", imem_address, 32'h4000_2000);
    imem_resp = 1'b1; imem_rdata = 32'h0000_0013;
    tick();
    imem_resp = 1'b0;
    check("last_redirect_wins", imem_address, 32'hFFFF_FFFC);

    // jal x1,8 at the top of memory: PC wraps to 0
    iq_if.ack_o = 1'b1;
    exp_q.push_back(mk(JAL, 3'd0, 7'd0, 5'd1, 5'd0, 5'd0, 32'd8, 32'hFFFF_FFFC));
    mem_fetch(32'h0080_00EF, 0, 32'hFFFF_FFFC);
    tick();
    check("pc_wrap", imem_address, 32'h0000_0000);

    // lw x6,-4(x7)
    exp_q.push_back(mk(LD, 3'd2, 7'h7F, 5'd6, 5'd7, 5'd0, 32'hFFFF_FFFC, 32'h0000_0000));
    mem_fetch(32'hFFC3_A303, 1, 32'h0000_0000);
    tick();
    check("lw_next_addr", imem_address, 32'h0000_0004);

    // reset while draining; the in-flight response is never delivered
    iq_if.ack_o = 1'b0;
    redirect = 1'b1; redirect_pc = 32'h4000_3000;
    tick();
    redirect = 1'b0;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("rst_drain_addr", imem_address, 32'h4000_0060);
    check("rst_drain_read", {31'd0, imem_read}, 32'd1);
    check("rst_drain_ld_iq", {31'd0, iq_if.ld_iq}, 32'd0);
    tick();
    iq_if.ack_o = 1'b1;
    exp_q.push_back(mk(ALU, 3'd0, 7'd0, 5'd1, 5'd2, 5'd0, 32'd5, 32'h4000_0060));
    mem_fetch(32'h0051_0093, 0, 32'h4000_0060);
    tick();
    iq_if.ack_o = 1'b0;
    check("post_rst_next_addr", imem_address, 32'h4000_0064);

    tick();
    check("exp_q_drained", exp_q.size(), 32'd0);
    check("addr_q_drained", addr_q.size(), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/instr_fetch_decode.md
# instr_fetch_decode

Front-end producer for the Tomasulo issue path: fetches one RV32I instruction at a time from the instruction memory port, decodes it into a `tomasula_types::ctl_word`, and offers it to the instruction queue over the `IQ_2_IR` handshake (`ld_iq` / `ack_o` / `issue_q_full_n`). It owns the architectural fetch PC. It accepts a redirect from the commit/branch logic that discards any wrong-path instruction.

## Interface
- `RESET_PC`, default `32'h4000_0060`: PC loaded on reset.
- `clk` in, 1: single clock, all state updates on rising edge.
- `rst` in, 1: synchronous, active-high reset.
- `imem_address` out, 32: fetch address; always equals the current PC, word aligned.
- `imem_read` out, 1: fetch request; held high until `imem_resp`.
- `imem_resp` in, 1: one-cycle pulse; `imem_rdata` valid this cycle.
- `imem_rdata` in, 32: instruction word.
- `redirect` in, 1: one-cycle pulse; the PC becomes `redirect_pc`.
- `redirect_pc` in, 32: new fetch target, word aligned.
- `iq_ir_itf` modport `IQ_2_IR.IR_SIG`, carrying:
  - `ld_iq` out, 1: request to enqueue.
  - `control_word` out, ctl_word: decoded instruction.
  - `ack_o` in, 1: same-cycle accept from the queue.
  - `issue_q_full_n` in, 1: queue has space. Informational only.

## Operation
- States:
  - `FETCH`: `imem_read`=1.
  - `ISSUE`: `ld_iq`=1.
  - `DRAIN`: `imem_read`=1 on a stale address; the response is discarded.
- Reset values: state=`FETCH`, PC=`RESET_PC`, instruction register=`32'h0000_0013` (nop). The clocked state is reset, so the outputs take these values on the first cycle after `rst`: `imem_read`=1, `ld_iq`=0, `control_word` = decode of the nop.
- `FETCH` transitions:
  - `imem_resp`, no `redirect`: latch `imem_rdata` into the IR and go to `ISSUE`.
  - `imem_resp` with `redirect`: drop the data, PC←`redirect_pc`, stay in `FETCH`.
  - `redirect` without `imem_resp`: save `redirect_pc` as the pending PC and go to `DRAIN`. `imem_address` stays at the old PC until the response arrives.
- `DRAIN`:
  - On `imem_resp`: PC←pending PC, then go to `FETCH`.
  - A further `redirect` during `DRAIN` overwrites the pending PC; the last redirect wins.
- `ISSUE`:
  - `control_word` is combinational decode of the IR and stays stable while `ld_iq`=1.
  - On `ack_o`: PC←PC+4 (mod 2^32, wraps silently) and go to `FETCH`.
  - On `redirect`: PC←`redirect_pc` and go to `FETCH`. If `ack_o` arrives in the same cycle, the word counts as enqueued; its squash is the queue/ROB's job.
  - `ld_iq` is never withdrawn except by `redirect` or `rst`.
- Decode fields written into ctl_word:
  - `op` from the opcode: `ALU` (OP, OP-IMM), `LD`, `ST`, `BR`, `JAL`, `JALR`, `LUI`, `AUIPC`. Any other opcode gives `op`=`ALU` with `rd`=0, i.e. a nop.
  - `funct3`, `funct7`, `rd`, `src1_reg` and `src2_reg` come straight from the instruction word.
  - `src2_reg`=0 for I/U/J formats.
  - `src1_reg`=0 for U/J formats.
  - `rd`=0 for S/B formats.
  - `imm`: 32-bit value, sign-extended per I/S/B/U/J format.
  - `pc`: the instruction's PC.
- `rst` takes effect in any state, including mid-fetch. The bench's memory model must discard any in-flight response after reset.

## Timing
- `imem_read` rises the cycle after `rst` falls.
- `imem_resp` in cycle N puts `ld_iq`=1 in cycle N+1.
- `ack_o` in cycle M puts `imem_read`=1 with PC+4 in cycle M+1.
- Best-case throughput is one instruction per (mem latency + 2) cycles. No prefetch.
- `imem_address` and `control_word` are glitch-free registered/decoded values. No combinational path from `ack_o` to `ld_iq`.

## Structure
- `tomasula_types` package owns:
  - the `ctl_word` struct and the `op` enum;
  - RV32I opcode constants and the `RESET_PC` default.
- Sub-module `rv32i_decoder`: purely combinational, instruction word + PC → ctl_word.
- The FSM, PC, pending PC and IR stay in `instr_fetch_decode`.

## Test plan
- Reset with 1-cycle memory latency: cycle after `rst` shows `imem_address`=`32'h4000_0060` and `imem_read`=1.
- Fetch `32'h00510093` (addi x1,x2,5) with `ack_o` tied high: `ld_iq` asserts the cycle after `imem_resp` with `op`=`ALU`, `rd`=1, `src1_reg`=2, `src2_reg`=0, `imm`=5, `pc`=`32'h4000_0060`. Next fetch address is `32'h4000_0064`.
- Fetch `32'h00322423` (sw x3,8(x4)) with `ack_o` held low for 5 cycles: `ld_iq`=1 and `control_word` stable all 5 cycles (`op`=`ST`, `src1_reg`=4, `src2_reg`=3, `imm`=8, `rd`=0). PC advances only after `ack_o`.
- Memory latency 4, `redirect` to `32'h4000_1000` on the 2nd wait cycle: address held until `imem_resp`, data dropped, `ld_iq` stays 0. Next `imem_address`=`32'h4000_1000`.
- `redirect` to `32'h4000_2000` in `ISSUE` with `ack_o`=0: `ld_iq` drops next cycle and fetch resumes at `32'h4000_2000`. Repeat with `ack_o`=1 in the same cycle: the enqueue counts and PC is still `32'h4000_2000`.
- PC=`32'hFFFF_FFFC` with `ack_o`: next `imem_address`=`32'h0000_0000`. Separately, `rst` asserted in `DRAIN` returns to `FETCH` at `RESET_PC`.
